boot_rom_arbiter: RTL and testbench

Shares the single-port, 1-cycle-latency boot ROM between two read requesters: port 0 (instruction fetch) and port 1 (data/load path). Arbitration is round-robin, with a bounded burst so one port cannot starve the other. The block tracks which port owns the in-flight ROM read and returns the data with a per-port valid strobe. It sits between the CPU fetch/load units and the boot ROM.

---
 rtl/boot_rom_arbiter.sv | 87 ++++++++
 tb/tb_boot_rom_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_rom_arbiter.sv
// Round-robin, burst-limited arbiter sharing the boot ROM between the
// fetch port (0) and the load port (1), with a 1-cycle read-return pipe.
module boot_rom_arbiter #(
  parameter int BITS         = 32,
  parameter int ADDRESS_BITS = 10,
  parameter int MAX_BURST    = 4
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  input  logic                    p0_req,
  input  logic [ADDRESS_BITS-1:0] p0_addr,
  output logic                    p0_ack,
  output logic                    p0_rvalid,
  output logic [BITS-1:0]         p0_rdata,
  input  logic                    p1_req,
  input  logic [ADDRESS_BITS-1:0] p1_addr,
  output logic                    p1_ack,
  output logic                    p1_rvalid,
  output logic [BITS-1:0]         p1_rdata,
  output logic [ADDRESS_BITS-1:0] rom_addr,
  input  logic [BITS-1:0]         rom_data
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  logic          owner;
  logic          fresh;
  logic [CW-1:0] burst_cnt;
  logic          g0;
  logic          g1;
  logic          sel;

  // Until the first grant after reset the owner holds no claim,
  // so the first contention goes to port 0.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (p0_req && p1_req) begin
      if (!fresh && burst_cnt < MAX_CNT) begin
        g0 = !owner;
        g1 = owner;
      end else begin
        g0 = owner;
        g1 = !owner;
      end
    end else begin
      g0 = p0_req;
      g1 = p1_req;
    end
  end

  assign p0_ack = g0;
  assign p1_ack = g1;

  assign sel      = g1 | (!g0 & owner);
  assign rom_addr = sel ? p1_addr : p0_addr;

  assign p0_rdata = rom_data;
  assign p1_rdata = rom_data;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      owner     <= 1'b1;
      fresh     <= 1'b1;
      burst_cnt <= '0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
    end else begin
      p0_rvalid <= g0;
      p1_rvalid <= g1;
      if (g0 || g1) begin
        fresh <= 1'b0;
        if (g1 == owner) begin
          if (burst_cnt != MAX_CNT)
            burst_cnt <= burst_cnt + 1'b1;
        end else begin
          owner     <= g1;
          burst_cnt <= CW'(1);
        end
      end else begin
        burst_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Bench for boot_rom_arbiter: two instances (MAX_BURST 4 and 1) driven by
// shared stimulus and checked against a rule-level arbitration model.
module tb_boot_rom_arbiter;

  localparam int B = 32;
  localparam int A = 10;

  logic CLK = 1'b0;
  logic RSTb = 1'b0;
  always #5 CLK = ~CLK;

  logic         p0_req = 1'b0;
  logic         p1_req = 1'b0;
  logic [A-1:0] p0_addr = '0;
  logic [A-1:0] p1_addr = '0;

  logic [1:0]        ack0, ack1, rv0, rv1;
  logic [1:0][B-1:0] rd0, rd1, rom;
  logic [1:0][A-1:0] ra;

  logic [B-1:0] mem [0:(1<<A)-1];

  int checks = 0;
  int errors = 0;

  int           mb [2] = '{4, 1};
  int           m_own [2];
  int           m_cnt [2];
  bit           m_fresh [2];
  int           m_rv [2];
  logic [A-1:0] m_ra [2];

  boot_rom_arbiter #(.BITS(B), .ADDRESS_BITS(A), .MAX_BURST(4)) u4 (
    .CLK(CLK), .RSTb(RSTb),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(ack0[0]),
    .p0_rvalid(rv0[0]), .p0_rdata(rd0[0]),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_ack(ack1[0]),
    .p1_rvalid(rv1[0]), .p1_rdata(rd1[0]),
    .rom_addr(ra[0]), .rom_data(rom[0])
  );

  boot_rom_arbiter #(.BITS(B), .ADDRESS_BITS(A), .MAX_BURST(1)) u1 (
    .CLK(CLK), .RSTb(RSTb),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(ack0[1]),
    .p0_rvalid(rv0[1]), .p0_rdata(rd0[1]),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_ack(ack1[1]),
    .p1_rvalid(rv1[1]), .p1_rdata(rd1[1]),
    .rom_addr(ra[1]), .rom_data(rom[1])
  );

  always @(posedge CLK) begin
    rom[0] <= mem[ra[0]];
    rom[1] <= mem[ra[1]];
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      m_own[k]   = 1;
      m_cnt[k]   = 0;
      m_fresh[k] = 1'b1;
      m_rv[k]    = -1;
    end
  endtask

  function automatic int grant(int k);
    if (p0_req && p1_req) begin
      if (!m_fresh[k] && m_cnt[k] < mb[k]) return m_own[k];
      return 1 - m_own[k];
    end
    if (p0_req) return 0;
    if (p1_req) return 1;
    return -1;
  endfunction

  task automatic check_all();
    int g;
    logic [A-1:0] ea;
    for (int k = 0; k < 2; k++) begin
      g = grant(k);
      ea = (g == 1 || (g < 0 && m_own[k] == 1)) ? p1_addr : p0_addr;
      chk($sformatf("u%0d.ack0", k), ack0[k], g == 0);
      chk($sformatf("u%0d.ack1", k), ack1[k], g == 1);
      chk($sformatf("u%0d.rom_addr", k), ra[k], ea);
      chk($sformatf("u%0d.rvalid0", k), rv0[k], m_rv[k] == 0);
      chk($sformatf("u%0d.rvalid1", k), rv1[k], m_rv[k] == 1);
      if (m_rv[k] == 0) chk($sformatf("u%0d.rdata0", k), rd0[k], mem[m_ra[k]]);
      if (m_rv[k] == 1) chk($sformatf("u%0d.rdata1", k), rd1[k], mem[m_ra[k]]);
    end
  endtask

  task automatic update();
    int g;
    if (!RSTb) begin
      mreset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      g = grant(k);
      m_rv[k] = g;
      m_ra[k] = (g == 1) ? p1_addr : p0_addr;
      if (g >= 0) begin
        m_fresh[k] = 1'b0;
        if (g == m_own[k]) begin
          if (m_cnt[k] < mb[k]) m_cnt[k]++;
        end else begin
          m_own[k] = g;
          m_cnt[k] = 1;
        end
      end else begin
        m_cnt[k] = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    check_all();
    update();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << A); i++) mem[i] = $urandom;
    mreset();
    RSTb = 1'b0;
    tick();
    tick();
    RSTb = 1'b1;

    // single read from port 0
    p0_req = 1'b1;
    p0_addr = 10'h010;
    #2;
    chk("single.rom_addr", ra[0], 10'h010);
    tick();
    p0_req = 1'b0;
    #2;
    chk("single.rdata", rd0[0], mem[10'h010]);
    tick();
    tick();

    // continuous contention from reset
    RSTb = 1'b0;
    mreset();
    tick();
    RSTb = 1'b1;
    p0_req = 1'b1;
    p1_req = 1'b1;
    p0_addr = A'($urandom);
    p1_addr = A'($urandom);
    for (int i = 0; i < 10; i++) begin
      #2;
      chk($sformatf("burst4.p1_ack[%0d]", i), ack1[0], ((i / 4) % 2) == 1);
      chk($sformatf("burst1.p1_ack[%0d]", i), ack1[1], (i % 2) == 1);
      chk($sformatf("burst1.both[%0d]", i), ack0[1] & ack1[1], 1'b0);
      tick();
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick();
    tick();

    // port 0 streams 0..7 alone
    p0_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      p0_addr = A'(i);
      tick();
    end
    p0_req = 1'b0;
    tick();
    tick();

    // p1 takes over as p0 ends a 2-grant burst
    p0_req = 1'b1;
    p0_addr = 10'h005;
    tick();
    p0_addr = 10'h006;
    tick();
    p0_req = 1'b0;
    p1_req = 1'b1;
    p1_addr = 10'h009;
    #2;
    chk("handoff.p1_ack", ack1[0], 1'b1);
    tick();
    p1_req = 1'b0;
    tick();

    // asynchronous reset with a p1 response in flight
    p1_req = 1'b1;
    p1_addr = 10'h02a;
    tick();
    p1_req = 1'b0;
    #2;
    chk("areset.rv1_before", rv1[0], 1'b1);
    RSTb = 1'b0;
    mreset();
    #1;
    chk("areset.rv1_u4", rv1[0], 1'b0);
    chk("areset.rv1_u1", rv1[1], 1'b0);
    tick();
    tick();
    RSTb = 1'b1;
    tick();
    p0_req = 1'b1;
    p1_req = 1'b1;
    #2;
    chk("areset.first_p0", ack0[0], 1'b1);
    tick();
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick();
    tick();

    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      p0_req = 1'($urandom_range(0, 1));
      p1_req = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) p0_addr = A'($urandom);
      if ($urandom_range(0, 3) == 0) p1_addr = A'($urandom);
      if ($urandom_range(0, 60) == 0) begin
        RSTb = 1'b0;
        mreset();
        tick();
        RSTb = 1'b1;
      end
      tick();
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
